// File: rtl/eth_phy_10g_link_ctrl_if.sv
// Control and status bundle between the 10G PHY RX link controller and its
// surroundings (PHY RX status, SERDES reset, management counters).
interface eth_phy_10g_link_ctrl_if;
  logic        cfg_enable;
  logic        stat_clear;
  logic        rx_block_lock;
  logic        rx_high_ber;
  logic [6:0]  rx_error_count;
  logic        serdes_rx_reset_req;
  logic        serdes_rst;
  logic        link_up;
  logic        link_fault;
  logic [2:0]  state;
  logic [7:0]  retry_count;
  logic [7:0]  link_down_count;
  logic [15:0] err_accum;

  modport master (
    output cfg_enable, stat_clear, rx_block_lock, rx_high_ber,
           rx_error_count, serdes_rx_reset_req,
    input  serdes_rst, link_up, link_fault, state, retry_count,
           link_down_count, err_accum
  );

  modport slave (
    input  cfg_enable, stat_clear, rx_block_lock, rx_high_ber,
           rx_error_count, serdes_rx_reset_req,
    output serdes_rst, link_up, link_fault, state, retry_count,
           link_down_count, err_accum
  );
endinterface

// File: rtl/eth_phy_10g_link_ctrl.sv
// 10G PHY RX link bring-up controller: sequences SERDES reset, waits for block
// lock, qualifies stability, retries/faults, and keeps link statistics.
module eth_phy_10g_link_ctrl #(
  parameter int RESET_CYCLES  = 64,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  eth_phy_10g_link_ctrl_if.slave       bus
);

  localparam int TMAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int TMAX   = (TMAX_A > RESET_CYCLES) ? TMAX_A : RESET_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_DISABLED    = 3'd0,
    S_RESET       = 3'd1,
    S_WAIT_LOCK   = 3'd2,
    S_WAIT_STABLE = 3'd3,
    S_UP          = 3'd4,
    S_FAULT       = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_retry;
  logic [7:0]    r_link_down;
  logic [15:0]   r_err_accum;
  logic          r_serdes_rst;
  logic          r_link_up;
  logic          r_link_fault;
  logic          w_good;
  logic          w_retry_inc;
  logic          w_retry_clr;
  logic          w_drop;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [6:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {10'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign w_good = bus.rx_block_lock & ~bus.rx_high_ber;

  // Next-state selection plus the counter side effects tied to each transition.
  always_comb begin
    w_next      = r_state;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_drop      = 1'b0;
    if (r_state == S_DISABLED) begin
      w_retry_clr = 1'b1;
      if (bus.cfg_enable) begin
        w_next = S_RESET;
      end else begin
        w_next = S_DISABLED;
      end
    end else if (!bus.cfg_enable) begin
      w_next = S_DISABLED;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_timer == TW'(RESET_CYCLES - 1)) begin
            w_next = S_WAIT_LOCK;
          end else begin
            w_next = S_RESET;
          end
        end
        S_WAIT_LOCK: begin
          if (w_good) begin
            w_next = S_WAIT_STABLE;
          end else if (r_timer == TW'(LOCK_TIMEOUT - 1) && r_retry == 8'(MAX_RETRIES)) begin
            w_next = S_FAULT;
          end else if (r_timer == TW'(LOCK_TIMEOUT - 1)) begin
            w_next      = S_RESET;
            w_retry_inc = 1'b1;
          end else begin
            w_next = S_WAIT_LOCK;
          end
        end
        S_WAIT_STABLE: begin
          if (!w_good) begin
            w_next = S_WAIT_LOCK;
          end else if (r_timer == TW'(STABLE_CYCLES - 1)) begin
            w_next      = S_UP;
            w_retry_clr = 1'b1;
          end else begin
            w_next = S_WAIT_STABLE;
          end
        end
        S_UP: begin
          // A PHY-requested reset is not a link drop, so it outranks loss of lock.
          if (bus.serdes_rx_reset_req) begin
            w_next = S_RESET;
          end else if (!w_good) begin
            w_next = S_WAIT_LOCK;
            w_drop = 1'b1;
          end else begin
            w_next = S_UP;
          end
        end
        S_FAULT: w_next = S_FAULT;
        default: w_next = S_DISABLED;
      endcase
    end
  end

  // State, timer and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_DISABLED;
      r_timer      <= '0;
      r_serdes_rst <= 1'b0;
      r_link_up    <= 1'b0;
      r_link_fault <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_timer      <= (w_next != r_state) ? '0 : r_timer + TW'(1);
      r_serdes_rst <= (r_state == S_RESET);
      r_link_up    <= (r_state == S_UP);
      r_link_fault <= (r_state == S_FAULT);
    end
  end

  // Retry and statistics counters; stat_clear beats any coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retry     <= 8'd0;
      r_link_down <= 8'd0;
      r_err_accum <= 16'd0;
    end else begin
      if (w_retry_clr) begin
        r_retry <= 8'd0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 8'd1;
      end else begin
        r_retry <= r_retry;
      end
      if (bus.stat_clear) begin
        r_link_down <= 8'd0;
        r_err_accum <= 16'd0;
      end else begin
        r_link_down <= (w_drop && r_link_down != 8'hFF) ? r_link_down + 8'd1 : r_link_down;
        r_err_accum <= (r_state == S_UP) ? sat_add16(r_err_accum, bus.rx_error_count) : r_err_accum;
      end
    end
  end

  assign bus.state           = r_state;
  assign bus.serdes_rst      = r_serdes_rst;
  assign bus.link_up         = r_link_up;
  assign bus.link_fault      = r_link_fault;
  assign bus.retry_count     = r_retry;
  assign bus.link_down_count = r_link_down;
  assign bus.err_accum       = r_err_accum;

endmodule

// File: doc/eth_phy_10g_link_ctrl.md
Name: eth_phy_10g_link_ctrl

Overview:
Link bring-up and supervision controller for the 10G PHY receive path. It sequences SERDES receive reset, waits for block lock, and qualifies link stability before declaring link up. It retries on lock timeout and latches a fault after repeated failures. It also accumulates BER error counts and link-drop statistics for the management block.

Parameters:
RESET_CYCLES, 64, cycles serdes_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry (>=2)
STABLE_CYCLES, 1024, cycles of continuous lock with no high BER required before UP (>=1)
MAX_RETRIES, 15, consecutive failed lock attempts tolerated before FAULT (1..255)

Ports:
clk  in  1  PHY RX clock
rst  in  1  synchronous active-high reset
cfg_enable  in  1  1 = run link bring-up; 0 = force DISABLED
stat_clear  in  1  single-cycle pulse; clears statistics counters
rx_block_lock  in  1  block lock status from the PHY RX
rx_high_ber  in  1  high-BER status from the PHY RX
rx_error_count  in  7  per-cycle errored-block count from the PHY RX
serdes_rx_reset_req  in  1  PHY request to reset the SERDES RX
serdes_rst  out  1  SERDES RX reset, active high
link_up  out  1  link qualified and up
link_fault  out  1  retries exhausted
state  out  3  0 DISABLED, 1 RESET, 2 WAIT_LOCK, 3 WAIT_STABLE, 4 UP, 5 FAULT
retry_count  out  8  consecutive failed lock attempts
link_down_count  out  8  saturating count of UP->WAIT_LOCK drops
err_accum  out  16  saturating sum of rx_error_count while UP

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high, on signal rst.
- All outputs are registered. On rst: state=DISABLED, every counter and output = 0.
- serdes_rst = (state==RESET); link_up = (state==UP); link_fault = (state==FAULT). Each has 1-cycle latency from the state register.
- timer clears on every state change and otherwise increments each cycle. The timer is wide enough for max(LOCK_TIMEOUT, STABLE_CYCLES, RESET_CYCLES).
- "good" = rx_block_lock & !rx_high_ber.
- Priority in every state except DISABLED: cfg_enable=0 sends the next state to DISABLED, overriding all other transitions.
- DISABLED: cfg_enable=1 -> RESET. retry_count is cleared while in DISABLED.
- RESET: timer==RESET_CYCLES-1 -> WAIT_LOCK. serdes_rst is therefore high for exactly RESET_CYCLES cycles.
- WAIT_LOCK, evaluated in this order:
  - good -> WAIT_STABLE.
  - else timer==LOCK_TIMEOUT-1 and retry_count==MAX_RETRIES -> FAULT.
  - else timer==LOCK_TIMEOUT-1 -> RESET and retry_count+1.
- WAIT_STABLE:
  - !good -> WAIT_LOCK (timer restarts; no retry increment).
  - else timer==STABLE_CYCLES-1 -> UP and retry_count=0.
- UP:
  - serdes_rx_reset_req -> RESET (takes priority over !good; no link_down increment).
  - else !good -> WAIT_LOCK and link_down_count+1 (saturates at 255).
- FAULT: held until cfg_enable=0. The next cfg_enable=1 restarts from RESET with retry_count=0.
- serdes_rx_reset_req is ignored outside UP.
- err_accum: in each UP cycle adds the zero-extended rx_error_count, saturating at 0xFFFF. It holds in all other states.
- stat_clear zeros err_accum and link_down_count. If an increment coincides with stat_clear, clear wins and the increment is discarded. stat_clear does not affect retry_count or state.
- rst mid-operation: state returns to DISABLED next cycle and serdes_rst deasserts. Counters clear regardless of current state.

Test Plan:
Bench parameters for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Normal bring-up: rst, then cfg_enable=1, with lock=1 and high_ber=0 from cycle 0 -> serdes_rst high exactly 4 cycles, WAIT_STABLE for 8 cycles, then link_up=1; retry_count=0.
- No lock: lock held 0 -> three RESET/WAIT_LOCK rounds (retry_count 0->1->2), then FAULT with link_fault=1. Drop cfg_enable for 1 cycle, then set it to 1 -> state=RESET, retry_count=0.
- Stability glitch: lock drops for 1 cycle at WAIT_STABLE timer=5 -> returns to WAIT_LOCK with no retry increment. Once lock returns, link_up asserts 8 cycles later.
- Link drop and PHY reset request:
  - In UP, pulse high_ber -> WAIT_LOCK and link_down_count=1.
  - In UP, assert serdes_rx_reset_req together with lock=0 -> RESET, link_down_count unchanged.
- Error accumulation: in UP, drive rx_error_count=127 for 600 cycles -> err_accum saturates at 0xFFFF. stat_clear coincident with a drop -> err_accum=0 and link_down_count=0.
- Reset mid-RESET: assert rst while serdes_rst=1 -> next cycle state=0 and serdes_rst=0, all counters 0.
